// File: rtl/water_sensor_conditioner_pkg.sv
// Shared definitions for the water-level sensor conditioner.
// Holds the level-vector encodings, the FSM state type and the plausibility rule.
package water_sensor_conditioner_pkg;

  localparam logic [2:0] LVL_EMPTY = 3'b000;
  localparam logic [2:0] LVL_LOW   = 3'b001;
  localparam logic [2:0] LVL_HALF  = 3'b011;
  localparam logic [2:0] LVL_FULL  = 3'b111;

  typedef enum logic [1:0] {
    ST_NORMAL  = 2'd0,
    ST_SUSPECT = 2'd1,
    ST_FAULT   = 2'd2
  } state_t;

  // Float switches stack bottom-up, so a higher switch can only be wet when
  // every switch below it is wet.
  function automatic logic is_plausible(input logic [2:0] lvl);
    return (lvl == LVL_EMPTY) || (lvl == LVL_LOW) ||
           (lvl == LVL_HALF)  || (lvl == LVL_FULL);
  endfunction

endpackage

// File: rtl/water_sensor_conditioner_debounce.sv
// Two-flop synchroniser followed by a saturating-free debounce counter for
// one float switch; the debounced bit flips after DEBOUNCE_CNT stable samples.
module sensor_debounce #(
  parameter int DEBOUNCE_CNT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic deb
);

  localparam int CW = $clog2(DEBOUNCE_CNT + 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          deb_q;
  logic          deb_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    deb_d = deb_q;
    cnt_d = '0;
    if (sync2_q != deb_q) begin
      // The edge that would bring the count to DEBOUNCE_CNT accepts the change
      // and clears the counter, so it never holds DEBOUNCE_CNT or wraps.
      if (cnt_q == CW'(DEBOUNCE_CNT - 1)) begin
        deb_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      deb_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
    end
  end

  assign deb = deb_q;

endmodule

// File: rtl/water_sensor_conditioner.sv
// Conditions three float switches into a plausible level vector for the pump
// controller, forcing "full" (motor off) when the sensors stay inconsistent.
module water_sensor_conditioner
  import water_sensor_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CNT = 16,
  parameter int FAULT_CNT    = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_s1,
  input  logic raw_s2,
  input  logic raw_s3,
  input  logic fault_clr,
  output logic S1,
  output logic S2,
  output logic S3,
  output logic fault
);

  localparam int FW = $clog2(FAULT_CNT + 1);

  logic [2:0]    raw_vec;
  logic [2:0]    deb_vec;
  logic          plaus;
  state_t        state_q;
  state_t        state_d;
  logic [FW-1:0] fcnt_q;
  logic [FW-1:0] fcnt_d;
  logic [2:0]    lvl_q;
  logic [2:0]    lvl_d;
  logic          fault_q;
  logic          fault_d;

  assign raw_vec = {raw_s3, raw_s2, raw_s1};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_deb
      sensor_debounce #(
        .DEBOUNCE_CNT(DEBOUNCE_CNT)
      ) u_deb (
        .clk  (clk),
        .rst_n(rst_n),
        .raw  (raw_vec[gi]),
        .deb  (deb_vec[gi])
      );
    end
  endgenerate

  assign plaus = is_plausible(deb_vec);

  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    lvl_d   = lvl_q;
    fault_d = fault_q;
    unique case (state_q)
      ST_NORMAL: begin
        fcnt_d = '0;
        if (plaus) begin
          lvl_d = deb_vec;
        end else if (FAULT_CNT <= 1) begin
          state_d = ST_FAULT;
          fault_d = 1'b1;
          lvl_d   = LVL_FULL;
        end else begin
          // The first implausible cycle already counts toward the fault.
          state_d = ST_SUSPECT;
          fcnt_d  = FW'(1);
        end
      end
      ST_SUSPECT: begin
        if (plaus) begin
          state_d = ST_NORMAL;
          fcnt_d  = '0;
          lvl_d   = deb_vec;
        end else if (fcnt_q >= FW'(FAULT_CNT - 1)) begin
          state_d = ST_FAULT;
          fcnt_d  = '0;
          fault_d = 1'b1;
          lvl_d   = LVL_FULL;
        end else begin
          fcnt_d = fcnt_q + 1'b1;
        end
      end
      ST_FAULT: begin
        lvl_d   = LVL_FULL;
        fault_d = 1'b1;
        fcnt_d  = '0;
        if (fault_clr) begin
          fault_d = 1'b0;
          if (plaus) begin
            state_d = ST_NORMAL;
            lvl_d   = deb_vec;
          end else begin
            state_d = ST_SUSPECT;
            fcnt_d  = FW'(1);
          end
        end
      end
      default: begin
        state_d = ST_NORMAL;
        fcnt_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_NORMAL;
      fcnt_q  <= '0;
      lvl_q   <= LVL_EMPTY;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      lvl_q   <= lvl_d;
      fault_q <= fault_d;
    end
  end

  assign S1    = lvl_q[0];
  assign S2    = lvl_q[1];
  assign S3    = lvl_q[2];
  assign fault = fault_q;

endmodule

// File: doc/water_sensor_conditioner.md
WATER_SENSOR_CONDITIONER -- requirements
Module: water_sensor_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CNT, default 16: consecutive stable samples needed to accept a sensor change (legal range >= 1).
REQ-002 Parameter FAULT_CNT, default 64: consecutive implausible cycles needed to declare a fault (legal range >= 1).
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 raw_s1  input  1  unsynchronised bottom float switch.
REQ-006 raw_s2  input  1  unsynchronised middle float switch.
REQ-007 raw_s3  input  1  unsynchronised top float switch.
REQ-008 fault_clr  input  1  synchronous single-cycle pulse that clears a latched fault.
REQ-009 S1  output  1  conditioned bottom level, registered; feeds the level controller S1 input.
REQ-010 S2  output  1  conditioned middle level, registered; feeds the level controller S2 input.
REQ-011 S3  output  1  conditioned top level, registered; feeds the level controller S3 input.
REQ-012 fault  output  1  registered, sticky sensor-plausibility fault flag.

Function
REQ-013 Each raw input SHALL pass through a two-flop synchroniser before any other use.
REQ-014 Each synchronised bit SHALL have its own debounce counter. The counter increments each cycle the synchronised bit differs from the debounced bit. It clears on any cycle the two bits match.
REQ-015 The debounced bit SHALL take the synchronised value on the edge where the counter reaches DEBOUNCE_CNT. The counter SHALL clear on that same edge.
REQ-016 Debounce counters SHALL be $clog2(DEBOUNCE_CNT+1) bits wide and SHALL never wrap.
REQ-017 The debounced vector {s3,s2,s1} SHALL be plausible only for the values 000, 001, 011 and 111. All other values SHALL be implausible.
REQ-018 The FSM SHALL have three states: NORMAL, SUSPECT and FAULT.
REQ-019 In NORMAL with a plausible vector, {S3,S2,S1} SHALL register the debounced vector, for a total latency of DEBOUNCE_CNT+3 cycles from a stable raw change.
REQ-020 NORMAL SHALL move to SUSPECT when the vector is implausible. In SUSPECT, S1..S3 SHALL hold their last plausible value.
REQ-021 SUSPECT SHALL count consecutive implausible cycles, including the entry cycle, in a $clog2(FAULT_CNT+1)-bit counter. It SHALL return to NORMAL and clear the counter on any plausible cycle.
REQ-022 SUSPECT SHALL move to FAULT when the counter reaches FAULT_CNT. fault SHALL be 1 from the next edge onward.
REQ-023 In FAULT, {S3,S2,S1} SHALL be forced to 111 so the downstream controller stops the motor. This holds whatever the sensor state.
REQ-024 FAULT SHALL be left only on fault_clr. The next state SHALL be NORMAL if the vector is plausible, otherwise SUSPECT with the counter restarted at 1.
REQ-025 fault_clr SHALL be ignored in NORMAL and SUSPECT.
REQ-026 If fault_clr coincides with the edge that would enter FAULT, FAULT SHALL be entered (clear is ignored outside FAULT).

Reset
REQ-027 While rst_n is low, S1, S2, S3 and fault SHALL be 0 immediately (asynchronously).
REQ-028 While rst_n is low, synchronisers, debounced bits and all counters SHALL be 0, and the FSM SHALL be NORMAL.
REQ-029 Reset asserted mid-debounce or mid-SUSPECT SHALL discard all partial counts. There SHALL be no stale transition after release.

Structure
REQ-030 A shared package SHALL hold the level-vector constants LVL_EMPTY=000, LVL_LOW=001, LVL_HALF=011 and LVL_FULL=111.
REQ-031 The same shared package SHALL hold the FSM state encoding and a plausibility-check function.
REQ-032 The synchroniser and debounce logic SHALL live in one sub-module, sensor_debounce, parameterised by DEBOUNCE_CNT and instantiated three times.

Verification (DEBOUNCE_CNT=4, FAULT_CNT=8)
REQ-033 Release reset, then hold raw=001 -> S1 rises 7 cycles after raw_s1 rises; S2=S3=0; fault=0.
REQ-034 Raise raw_s2 for 3 cycles, then drop it -> {S3,S2,S1} stays 001; the S2 debounce counter clears.
REQ-035 From 001, hold raw=101 -> S stays 001 for 8 implausible cycles; then fault=1 and S=111. Restore raw=011 -> fault stays 1 and S stays 111.
REQ-036 Pulse fault_clr with the debounced vector at 011 -> next edge fault=0, S=011, state NORMAL.
REQ-037 Hold the implausible vector for 7 cycles, then restore a plausible one -> no fault; S updates to the new plausible value.
REQ-038 Drop rst_n mid-debounce while in FAULT -> S=000 and fault=0 immediately. After release, the first S change is no earlier than 7 cycles.
